// File: rtl/rm_head_win.sv
// rm_head_win: per-frame head trim and optional window limit on a CH-channel sample bus.
// Optional macro RM_HEAD_WIN_LIMIT_EN enables the win_len tail limit, oeof and the DONE state.
module rm_head_win #(
  parameter int CH    = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_rst,
  input  logic [CNT_W-1:0]    head_num,
  input  logic [CNT_W-1:0]    win_len,
  input  logic                ivld,
  input  logic                isof,
  input  logic [CH*DW-1:0]    idata,
  output logic                ovld,
  output logic                osof,
  output logic                oeof,
  output logic [CH*DW-1:0]    odata,
  output logic                win_done,
  output logic [1:0]          dbg_state_o
);

  // Handshake: valid-only streaming. A sample is present whenever ivld is high;
  // there is no ready, so every ovld cycle must be consumed by the sink.

  localparam logic [1:0] SKIP = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  head_d1_q, head_d2_q;
  logic [CNT_W-1:0]  head_act_q, head_act_d;
  logic [CNT_W-1:0]  len_eff;
  logic              ovld_q, ovld_d;
  logic              osof_q, osof_d;
  logic              oeof_q, oeof_d;
  logic [CH*DW-1:0]  odata_q;

`ifdef RM_HEAD_WIN_LIMIT_EN
  logic [CNT_W-1:0]  len_d1_q, len_d2_q;
  logic [CNT_W-1:0]  len_act_q, len_act_d;
`else
  logic              unused_win_len;
  assign unused_win_len = ^win_len;
`endif

  logic              restart;
  logic [1:0]        cur_state;
  logic [CNT_W-1:0]  cur_skip;
  logic [CNT_W-1:0]  cur_pass;
  logic [CNT_W-1:0]  head_eff;

  assign restart = ivld && isof;

  // A frame start is evaluated against the freshly loaded limits, not the stale active copy.
  always_comb begin
    head_eff = restart ? head_d2_q : head_act_q;
`ifdef RM_HEAD_WIN_LIMIT_EN
    len_eff  = restart ? len_d2_q : len_act_q;
`else
    len_eff  = '0;
`endif
  end

  always_comb begin
    cur_state = restart ? SKIP : state_q;
    cur_skip  = restart ? '0 : skip_cnt_q;
    cur_pass  = restart ? '0 : pass_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    pass_cnt_d = pass_cnt_q;
    head_act_d = head_act_q;
`ifdef RM_HEAD_WIN_LIMIT_EN
    len_act_d  = len_act_q;
`endif
    ovld_d     = 1'b0;
    osof_d     = 1'b0;
    oeof_d     = 1'b0;

    if (cfg_rst) begin
      state_d    = SKIP;
      skip_cnt_d = '0;
      pass_cnt_d = '0;
      head_act_d = head_d2_q;
`ifdef RM_HEAD_WIN_LIMIT_EN
      len_act_d  = len_d2_q;
`endif
    end else if (ivld) begin
      if (isof) begin
        head_act_d = head_d2_q;
`ifdef RM_HEAD_WIN_LIMIT_EN
        len_act_d  = len_d2_q;
`endif
      end
      state_d    = cur_state;
      skip_cnt_d = cur_skip;
      pass_cnt_d = cur_pass;
      case (cur_state)
        SKIP: begin
          if (cur_skip == head_eff) begin
            ovld_d     = 1'b1;
            osof_d     = 1'b1;
            pass_cnt_d = CNT_W'(1);
            if (len_eff == CNT_W'(1)) begin
              oeof_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = PASS;
            end
          end else begin
            skip_cnt_d = cur_skip + CNT_W'(1);
          end
        end
        PASS: begin
          ovld_d     = 1'b1;
          pass_cnt_d = (&cur_pass) ? cur_pass : cur_pass + CNT_W'(1);
          if ((len_eff != '0) && (cur_pass == len_eff - CNT_W'(1))) begin
            oeof_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = SKIP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_d1_q  <= '0;
      head_d2_q  <= '0;
      head_act_q <= '0;
      state_q    <= SKIP;
      skip_cnt_q <= '0;
      pass_cnt_q <= '0;
      ovld_q     <= 1'b0;
      osof_q     <= 1'b0;
      oeof_q     <= 1'b0;
      odata_q    <= '0;
    end else begin
      head_d1_q  <= head_num;
      head_d2_q  <= head_d1_q;
      head_act_q <= head_act_d;
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      ovld_q     <= ovld_d;
      osof_q     <= osof_d;
      oeof_q     <= oeof_d;
      if (ovld_d) begin
        odata_q <= idata;
      end
    end
  end

`ifdef RM_HEAD_WIN_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_d1_q  <= '0;
      len_d2_q  <= '0;
      len_act_q <= '0;
    end else begin
      len_d1_q  <= win_len;
      len_d2_q  <= len_d1_q;
      len_act_q <= len_act_d;
    end
  end

  assign oeof     = oeof_q;
  assign win_done = (state_q == DONE);
`else
  logic unused_oeof;
  assign unused_oeof = oeof_q;
  assign oeof        = 1'b0;
  assign win_done    = 1'b0;
`endif

  assign ovld        = ovld_q;
  assign osof        = osof_q;
  assign odata       = odata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rm_head_win.sv
// Directed bench for rm_head_win: expected outputs are queued at drive time and
// popped by an independent monitor whenever ovld is seen.
module tb_rm_head_win;

  localparam int CH    = 4;
  localparam int DW    = 16;
  localparam int CNT_W = 16;
  localparam int W     = 32 + 2 + CH*DW;

`ifdef RM_HEAD_WIN_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  localparam logic [1:0] S_SKIP = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic               clk;
  logic               rst_n;
  logic               cfg_rst;
  logic [CNT_W-1:0]   head_num;
  logic [CNT_W-1:0]   win_len;
  logic               ivld;
  logic               isof;
  logic [CH*DW-1:0]   idata;
  logic               ovld;
  logic               osof;
  logic               oeof;
  logic [CH*DW-1:0]   odata;
  logic               win_done;
  logic [1:0]         dbg_state;

  int unsigned        cyc;
  int                 checks;
  int                 errors;
  logic [W-1:0]       exp_q[$];

  rm_head_win #(.CH(CH), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_rst     (cfg_rst),
    .head_num    (head_num),
    .win_len     (win_len),
    .ivld        (ivld),
    .isof        (isof),
    .idata       (idata),
    .ovld        (ovld),
    .osof        (osof),
    .oeof        (oeof),
    .odata       (odata),
    .win_done    (win_done),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CH*DW-1:0] mk(input logic [7:0] v);
    return {8'h30, v, 8'h20, v, 8'h10, v, 8'h00, v};
  endfunction

  task automatic chk(input string name, input logic [CH*DW-1:0] act, input logic [CH*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input logic sof, input logic fwd,
                      input logic esof, input logic eeof);
    ivld  = 1'b1;
    isof  = sof;
    idata = mk(v);
    if (fwd) exp_q.push_back({32'(cyc + 1), esof, eeof, mk(v)});
    @(posedge clk);
    #1;
    ivld    = 1'b0;
    isof    = 1'b0;
    cfg_rst = 1'b0;
  endtask

  task automatic setcfg(input int h, input int w);
    head_num = CNT_W'(h);
    win_len  = CNT_W'(w);
    idle(3);
  endtask

  task automatic restart();
    cfg_rst = 1'b1;
    @(posedge clk);
    #1;
    cfg_rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      checks++;
      if (ovld) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got odata=%h sof=%b eof=%b at cyc %0d, expected no output",
                   odata, osof, oeof, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({osof, oeof, odata} !== e[CH*DW+1:0] || cyc != e[W-1:CH*DW+2]) begin
            errors++;
            $display("FAIL out_sample: got sof=%b eof=%b odata=%h cyc=%0d, expected sof=%b eof=%b odata=%h cyc=%0d",
                     osof, oeof, odata, cyc, e[CH*DW+1], e[CH*DW], e[CH*DW-1:0], e[W-1:CH*DW+2]);
          end
        end
      end else if (osof || oeof) begin
        errors++;
        $display("FAIL marker_idle: got sof=%b eof=%b with ovld=0, expected 0 0", osof, oeof);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    cfg_rst  = 1'b0;
    head_num = '0;
    win_len  = '0;
    ivld     = 1'b0;
    isof     = 1'b0;
    idata    = '0;
    idle(3);

    chk("rst_ovld",     {63'd0, ovld},     '0);
    chk("rst_osof",     {63'd0, osof},     '0);
    chk("rst_oeof",     {63'd0, oeof},     '0);
    chk("rst_odata",    odata,             '0);
    chk("rst_win_done", {63'd0, win_done}, '0);
    chk("rst_state",    {62'd0, dbg_state}, {62'd0, S_SKIP});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // head 3, unlimited window
    setcfg(3, 0);
    restart();
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0, i >= 3, i == 3, 1'b0);
    idle(2);

    // head 2, window 4
    setcfg(2, 4);
    restart();
    for (int i = 0; i < 12; i++)
      send(8'(i), 1'b0, LIM ? (i >= 2 && i <= 5) : (i >= 2), i == 2, LIM && i == 5);
    idle(2);
    chk("win_done_after_w4", {63'd0, win_done}, {63'd0, LIM});

    // head 0, window 1, sample on isof forwarded directly
    setcfg(0, 1);
    send(8'hA5, 1'b1, 1'b1, 1'b1, LIM);
    send(8'hB0, 1'b0, !LIM, 1'b0, 1'b0);
    idle(2);
    chk("win_done_after_w1", {63'd0, win_done}, {63'd0, LIM});
    chk("state_after_w1", {62'd0, dbg_state}, {62'd0, LIM ? S_DONE : S_PASS});

    // new frame with head 1 from DONE
    setcfg(1, 1);
    send(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b1, 1'b1, LIM);
    send(8'h12, 1'b0, !LIM, 1'b0, 1'b0);
    idle(2);

    // cfg_rst together with isof during PASS
    setcfg(1, 0);
    send(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h21, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_rst = 1'b1;
    send(8'h23, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("state_after_cfg_rst", {62'd0, dbg_state}, {62'd0, S_SKIP});
    send(8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h25, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'h26, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // gapped valid, head 5, window 2
    setcfg(5, 2);
    restart();
    for (int i = 0; i < 12; i++) begin
      send(8'(8'h30 + i), 1'b0, LIM ? (i == 5 || i == 6) : (i >= 5), i == 5, LIM && i == 6);
      idle(2);
    end

    // asynchronous reset mid-frame
    setcfg(0, 0);
    restart();
    send(8'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ovld",  {63'd0, ovld}, '0);
    chk("midrst_odata", odata, '0);
    chk("midrst_state", {62'd0, dbg_state}, {62'd0, S_SKIP});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h50, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("odata_hold", odata, mk(8'h50));

    chk("queue_empty", 64'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
